// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle multiply/divide unit owning the HI/LO registers
//               of the pipelined MIPS core. One operation is accepted per
//               start pulse while idle. busy stays high for the configured
//               latency, and done pulses for one cycle when HI/LO are written.
//               mthi/mtlo write HI/LO directly at the issuing edge.
//
// Parameters  : W        operand and HI/LO width
//               MULT_LAT cycles from accepted mult/multu/madd/maddu to result
//               DIV_LAT  cycles from accepted div/divu to result
//
// Ports       : clk    in   rising-edge clock
//               rst    in   asynchronous reset, active-low
//               start  in   operation request
//               op     in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//                           6 madd, 7 maddu (6/7 only with MULDIV_MADD_EN)
//               a, b   in   operands rs / rt
//               flush  in   kill in-flight operation / suppress start
//               busy   out  operation in flight
//               done   out  one-cycle completion pulse
//               hi, lo out  HI / LO registers
//
// Option      : `define MULDIV_MADD_EN enables madd/maddu ({hi,lo} += a*b).
//               Without it, ops 6/7 are ignored like an idle cycle.
//
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int W        = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CW      = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

    localparam logic [c_CW-1:0] c_MULT_CNT = c_CW'(MULT_LAT - 1);
    localparam logic [c_CW-1:0] c_DIV_CNT  = c_CW'(DIV_LAT - 1);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MADDU = 3'd7;

    localparam logic [W-1:0] c_MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] c_ALL_ONES = {W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_done;

    logic            w_op_run;
    logic            w_op_long;
    logic            w_issue;
    logic            w_accept;
    logic            w_finish;
    logic [2*W-1:0]  w_res;

    // ------------------------------------------------------------------
    // Opcode decode: which ops start a multi-cycle run, and which latency
    // ------------------------------------------------------------------
    always_comb begin
        w_op_run  = 1'b0;
        w_op_long = 1'b0;
        case (op)
            c_OP_MULT, c_OP_MULTU: w_op_run = 1'b1;
            c_OP_DIV,  c_OP_DIVU: begin
                w_op_run  = 1'b1;
                w_op_long = 1'b1;
            end
`ifdef MULDIV_MADD_EN
            c_OP_MADD, c_OP_MADDU: w_op_run = 1'b1;
`endif
            default: w_op_run = 1'b0;
        endcase
    end

    // flush suppresses any start seen while idle, including mthi/mtlo
    assign w_issue  = (r_state == S_IDLE) && start && !flush;
    assign w_accept = w_issue && w_op_run;
    // flush wins over completion: the result is dropped
    assign w_finish = (r_state == S_RUN) && !flush && (r_cnt == '0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (flush || (r_cnt == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the operands captured at acceptance
    // ------------------------------------------------------------------
    logic signed [W-1:0]   w_sa;
    logic signed [W-1:0]   w_sb;
    logic signed [W-1:0]   w_q_s;
    logic signed [W-1:0]   w_r_s;
    logic        [W-1:0]   w_q_u;
    logic        [W-1:0]   w_r_u;
    logic signed [2*W-1:0] w_prod_s;
    logic        [2*W-1:0] w_prod_u;

    assign w_sa     = r_a;
    assign w_sb     = r_b;
    assign w_prod_s = $signed({{W{r_a[W-1]}}, r_a}) * $signed({{W{r_b[W-1]}}, r_b});
    assign w_prod_u = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
    // Divide-by-zero and signed overflow are overridden below, so the raw
    // quotient/remainder are only consumed for well-defined operands.
    assign w_q_s    = w_sa / w_sb;
    assign w_r_s    = w_sa % w_sb;
    assign w_q_u    = r_a / r_b;
    assign w_r_u    = r_a % r_b;

    always_comb begin
        w_res = '0;
        case (r_op)
            c_OP_MULT:  w_res = w_prod_s;
            c_OP_MULTU: w_res = w_prod_u;
            c_OP_DIV: begin
                if (r_b == '0)
                    w_res = {r_a, c_ALL_ONES};
                else if ((r_a == c_MOST_NEG) && (r_b == c_ALL_ONES))
                    w_res = {{W{1'b0}}, r_a};
                else
                    w_res = {w_r_s, w_q_s};
            end
            c_OP_DIVU: begin
                if (r_b == '0)
                    w_res = {r_a, c_ALL_ONES};
                else
                    w_res = {w_r_u, w_q_u};
            end
`ifdef MULDIV_MADD_EN
            // HI/LO cannot change while busy, so the live value equals
            // the addend at acceptance.
            c_OP_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
            c_OP_MADDU: w_res = {r_hi, r_lo} + w_prod_u;
`endif
            default:    w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture, countdown and HI/LO write-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;

            if (w_accept) begin
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_cnt <= w_op_long ? c_DIV_CNT : c_MULT_CNT;
            end else if (r_state == S_RUN) begin
                if (flush || (r_cnt == '0))
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt - 1'b1;
            end

            if (w_finish) begin
                r_hi <= w_res[2*W-1:W];
                r_lo <= w_res[W-1:0];
            end else if (w_issue && (op == c_OP_MTHI)) begin
                r_hi <= a;
            end else if (w_issue && (op == c_OP_MTLO)) begin
                r_lo <= a;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
